// File: rtl/keypad_entry_controller.sv
// rtl/keypad_entry_controller.sv - keypad synchroniser, debouncer, BCD entry register and tick divider
module keypad_entry_controller #(
   parameter int NUM_KEYS        = 10,
   parameter int DIGITS          = 4,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TICK_DIV        = 8
) (
   input  logic                          clk,
   input  logic                          clear,
   input  logic                          enablen,
   input  logic                          flush,
   input  logic [NUM_KEYS-1:0]           keypad,
   output logic                          load,
   output logic [3:0]                    digit,
   output logic [4*DIGITS-1:0]           entry,
   output logic [$clog2(DIGITS+1)-1:0]   count,
   output logic                          full,
   output logic                          overflow,
   output logic                          tick
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int DW = $clog2(TICK_DIV);
   localparam int NW = $clog2(DIGITS + 1);

   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
   localparam logic [NW-1:0] CNT_FULL_M1 = NW'(DIGITS - 1);
   localparam logic [NW-1:0] COUNT_ONE = NW'(1);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_PRESSED  = 2'd2,
      ST_RELEASE  = 2'd3
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         cnt_q;
   logic [3:0]            cand_q;
   logic [NUM_KEYS-1:0]   ks1_q;
   logic [NUM_KEYS-1:0]   ksync_q;
   logic                  load_q;
   logic [3:0]            digit_q;
   logic [4*DIGITS-1:0]   entry_q;
   logic [4*DIGITS-1:0]   entry_d;
   logic [NW-1:0]         count_q;
   logic                  full_q;
   logic                  overflow_q;
   logic [DW-1:0]         div_q;
   logic                  tick_q;

   logic [3:0]            key_code;
   logic                  key_valid;
   logic                  cand_match;
   logic                  accept_hit;
   logic                  load_fire;

   // Two-flop synchroniser for the asynchronous key lines
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         ks1_q   <= '0;
         ksync_q <= '0;
      end else begin
         ks1_q   <= keypad;
         ksync_q <= ks1_q;
      end
   end

   // Priority encoder: lowest pressed key index wins
   always_comb begin
      key_code  = 4'd0;
      key_valid = |ksync_q;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (ksync_q[i]) key_code = 4'(i);
      end
   end

   generate
      if (DIGITS == 1) begin : g_entry_one
         assign entry_d = cand_q;
      end else begin : g_entry_shift
         assign entry_d = {entry_q[4*DIGITS-5:0], cand_q};
      end
   endgenerate

   // The press is accepted on the edge that sees the final matching sample;
   // a same-edge flush swallows it entirely (no load, no overflow).
   assign cand_match = key_valid && (key_code == cand_q);
   assign accept_hit = (state_q == ST_DEBOUNCE) && !enablen && cand_match && (cnt_q == CNT_LAST);
   assign load_fire  = accept_hit && !flush && !full_q;

   // Press/release debounce FSM with registered entry outputs
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         cand_q     <= 4'd0;
         load_q     <= 1'b0;
         digit_q    <= 4'd0;
         entry_q    <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         load_q     <= load_fire;
         overflow_q <= accept_hit && !flush && full_q;

         if (flush) begin
            entry_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
         end else if (load_fire) begin
            digit_q <= cand_q;
            entry_q <= entry_d;
            count_q <= count_q + COUNT_ONE;
            full_q  <= (count_q == CNT_FULL_M1);
         end

         if (enablen) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (key_valid) begin
                     state_q <= ST_DEBOUNCE;
                     cand_q  <= key_code;
                     cnt_q   <= CNT_ONE;
                  end
               end
               ST_DEBOUNCE: begin
                  if (!cand_match) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= ST_PRESSED;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               ST_PRESSED: begin
                  if (!key_valid) begin
                     state_q <= ST_RELEASE;
                     cnt_q   <= CNT_ONE;
                  end
               end
               ST_RELEASE: begin
                  if (key_valid) begin
                     state_q <= ST_PRESSED;
                     cnt_q   <= '0;
                  end else if (cnt_q == CNT_LAST) begin
                     state_q <= ST_IDLE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CNT_ONE;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   // Free-running tick divider, restarted by every accepted press
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         div_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         tick_q <= (div_q == DIV_LAST);
         if (load_fire || (div_q == DIV_LAST)) begin
            div_q <= '0;
         end else begin
            div_q <= div_q + DW'(1);
         end
      end
   end

   assign load     = load_q;
   assign digit    = digit_q;
   assign entry    = entry_q;
   assign count    = count_q;
   assign full     = full_q;
   assign overflow = overflow_q;
   assign tick     = tick_q;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// tb/tb_keypad_entry_controller.sv - scoreboard bench for keypad_entry_controller
module tb_keypad_entry_controller;

   localparam int NK = 10;
   localparam int DIG = 4;
   localparam int DB = 4;
   localparam int TD = 8;

   logic          clk = 1'b0;
   logic          clear;
   logic          enablen;
   logic          flush;
   logic [NK-1:0] keypad;
   logic          load;
   logic [3:0]    digit;
   logic [15:0]   entry;
   logic [2:0]    count;
   logic          full;
   logic          overflow;
   logic          tick;

   keypad_entry_controller #(
      .NUM_KEYS(NK), .DIGITS(DIG), .DEBOUNCE_CYCLES(DB), .TICK_DIV(TD)
   ) dut (
      .clk(clk), .clear(clear), .enablen(enablen), .flush(flush), .keypad(keypad),
      .load(load), .digit(digit), .entry(entry), .count(count), .full(full),
      .overflow(overflow), .tick(tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      bit         ov;
      logic [3:0] dg;
      logic [15:0] en;
      int         cnt;
      bit         fl;
   } ev_t;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   ev_t evq[$];
   int tickq[$];

   // reference model state
   logic [NK-1:0] d1, d2;
   bit            armed;
   int            run, relrun;
   logic [3:0]    rcode, m_digit;
   int            digs[$];
   int            phase;

   int n_load = 0;
   int n_ovf = 0;
   int last_load = -1;
   bit tick_pending = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] m_entry();
      int e;
      e = 0;
      foreach (digs[i]) e = e * 16 + digs[i];
      return e[15:0];
   endfunction

   task automatic model_reset();
      d1 = '0; d2 = '0;
      armed = 1; run = 0; relrun = 0;
      rcode = 4'd0; m_digit = 4'd0;
      digs.delete();
      phase = 0;
      evq.delete();
      tickq.delete();
      tick_pending = 0;
   endtask

   // behavioural model: counts runs of identical samples, keeps entered digits in a queue
   always @(posedge clk) begin
      logic [NK-1:0] s;
      bit            vld, accept, did_load, found;
      logic [3:0]    code;
      ev_t           e;
      cyc++;
      if (clear) begin
         model_reset();
      end else begin
         s = d2; d2 = d1; d1 = keypad;
         vld = |s;
         code = 4'd0; found = 0;
         for (int i = 0; i < NK; i++) if (s[i] && !found) begin code = 4'(i); found = 1; end
         accept = 0;
         if (enablen) begin
            armed = 1; run = 0;
         end else if (armed) begin
            if (run == 0) begin
               if (vld) begin run = 1; rcode = code; end
            end else if (vld && code == rcode) begin
               run++;
               if (run == DB) begin accept = 1; armed = 0; relrun = 0; run = 0; end
            end else begin
               run = 0;
            end
         end else begin
            if (vld) relrun = 0;
            else begin
               relrun++;
               if (relrun == DB) begin armed = 1; run = 0; end
            end
         end
         did_load = 0;
         if (flush) begin
            digs.delete();
         end else if (accept) begin
            if (digs.size() == DIG) begin
               e.ov = 1;
            end else begin
               digs.push_back(int'(rcode));
               m_digit = rcode;
               did_load = 1;
               e.ov = 0;
            end
            e.cyc = cyc; e.dg = m_digit; e.en = m_entry();
            e.cnt = digs.size(); e.fl = (digs.size() == DIG);
            evq.push_back(e);
         end
         if (phase == TD - 1) tickq.push_back(cyc);
         phase = did_load ? 0 : (phase + 1) % TD;
      end
   end

   // monitor: pops expected events whenever the DUT pulses load/overflow/tick
   always @(negedge clk) begin
      ev_t e;
      if (!clear) begin
         while (evq.size() > 0 && evq[0].cyc < cyc) begin
            e = evq.pop_front();
            n_vec++; n_err++;
            $display("FAIL missed_event: got none, expected event at cycle %0d", e.cyc);
         end
         while (tickq.size() > 0 && tickq[0] < cyc) begin
            n_vec++; n_err++;
            $display("FAIL missed_tick: got none, expected tick at cycle %0d", tickq.pop_front());
         end
         if (tick) begin
            if (tick_pending) begin
               chk("tick_after_load", 64'(cyc - last_load), 64'(TD));
               tick_pending = 0;
            end
            if (tickq.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_tick: got tick at cycle %0d, expected none", cyc);
            end else begin
               chk("tick_cycle", 64'(cyc), 64'(tickq.pop_front()));
            end
         end
         if (load || overflow) begin
            if (load) begin n_load++; last_load = cyc; tick_pending = 1; end
            if (overflow) n_ovf++;
            if (evq.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_event: got load=%0b overflow=%0b at cycle %0d, expected none",
                        load, overflow, cyc);
            end else begin
               e = evq.pop_front();
               chk("ev_cycle", 64'(cyc), 64'(e.cyc));
               chk("ev_load", 64'(load), 64'(!e.ov));
               chk("ev_overflow", 64'(overflow), 64'(e.ov));
               chk("ev_digit", 64'(digit), 64'(e.dg));
               chk("ev_entry", 64'(entry), 64'(e.en));
               chk("ev_count", 64'(count), 64'(e.cnt));
               chk("ev_full", 64'(full), 64'(e.fl));
            end
         end
      end
   end

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_load(input int lim, output int at);
      at = -1;
      for (int i = 0; i < lim; i++) begin
         @(posedge clk); #1;
         if (load) begin at = cyc; break; end
      end
   endtask

   task automatic wait_tick(input int lim, output int at);
      at = -1;
      for (int i = 0; i < lim; i++) begin
         @(posedge clk); #1;
         if (tick) begin at = cyc; break; end
      end
   endtask

   task automatic press(input int key);
      keypad = NK'(1) << key;
      repeat (8) nxt();
      keypad = '0;
      repeat (8) nxt();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_load"}, 64'(load), 64'(0));
      chk({tag, "_digit"}, 64'(digit), 64'(0));
      chk({tag, "_entry"}, 64'(entry), 64'(0));
      chk({tag, "_count"}, 64'(count), 64'(0));
      chk({tag, "_full"}, 64'(full), 64'(0));
      chk({tag, "_overflow"}, 64'(overflow), 64'(0));
      chk({tag, "_tick"}, 64'(tick), 64'(0));
   endtask

   initial begin
      int c0, lc, n0, o0, t1, t2, r, dur, k;
      clear = 1; enablen = 0; flush = 0; keypad = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      nxt();
      clear = 0;

      // single clean press of key 3
      nxt();
      keypad = NK'(10'b0000001000);
      c0 = cyc;
      wait_load(20, lc);
      chk("t1_latency", 64'(lc - c0), 64'(6));
      chk("t1_digit", 64'(digit), 64'(3));
      chk("t1_entry", 64'(entry), 64'(16'h0003));
      chk("t1_count", 64'(count), 64'(1));
      nxt();
      n0 = n_load;
      repeat (12) nxt();
      chk("t1_no_repeat", 64'(n_load - n0), 64'(0));
      keypad = '0;
      repeat (10) nxt();

      // press bounce then release bounce on key 5
      n0 = n_load;
      for (int i = 0; i < 4; i++) begin
         keypad = NK'(1) << 5; nxt(); nxt();
         keypad = '0; nxt();
      end
      chk("t2_bounce_no_load", 64'(n_load - n0), 64'(0));
      keypad = NK'(1) << 5;
      repeat (10) nxt();
      chk("t2_one_load", 64'(n_load - n0), 64'(1));
      chk("t2_digit", 64'(digit), 64'(5));
      for (int i = 0; i < 3; i++) begin
         keypad = '0; nxt();
         keypad = NK'(1) << 5; nxt(); nxt();
      end
      keypad = '0;
      repeat (10) nxt();
      chk("t2_release_no_load", 64'(n_load - n0), 64'(1));
      chk("t2_entry", 64'(entry), 64'(16'h0035));

      // fill, overflow, flush
      flush = 1; nxt(); flush = 0;
      chk("t3_preflush_count", 64'(count), 64'(0));
      press(1); press(2); press(3); press(4);
      chk("t3_entry", 64'(entry), 64'(16'h1234));
      chk("t3_full", 64'(full), 64'(1));
      chk("t3_count", 64'(count), 64'(4));
      o0 = n_ovf; n0 = n_load;
      press(9);
      chk("t3_overflow", 64'(n_ovf - o0), 64'(1));
      chk("t3_no_load", 64'(n_load - n0), 64'(0));
      chk("t3_entry_kept", 64'(entry), 64'(16'h1234));
      chk("t3_digit_kept", 64'(digit), 64'(4));
      flush = 1; nxt(); flush = 0;
      chk("t3_flush_entry", 64'(entry), 64'(0));
      chk("t3_flush_count", 64'(count), 64'(0));
      chk("t3_flush_full", 64'(full), 64'(0));

      // two keys together, then change while held
      n0 = n_load;
      keypad = NK'(10'b1000000100);
      repeat (8) nxt();
      chk("t4_digit", 64'(digit), 64'(2));
      chk("t4_one_load", 64'(n_load - n0), 64'(1));
      keypad = NK'(1) << 9;
      repeat (8) nxt();
      chk("t4_no_reload", 64'(n_load - n0), 64'(1));
      keypad = '0;
      repeat (8) nxt();

      // disabled press, then enable with key still held
      enablen = 1;
      keypad = NK'(1) << 7;
      n0 = n_load;
      repeat (10) nxt();
      chk("t5_disabled_no_load", 64'(n_load - n0), 64'(0));
      chk("t5_entry_kept", 64'(entry), 64'(16'h0002));
      enablen = 0;
      c0 = cyc;
      wait_load(20, lc);
      chk("t5_latency", 64'(lc - c0), 64'(4));
      chk("t5_digit", 64'(digit), 64'(7));
      nxt();
      keypad = '0;
      repeat (8) nxt();

      // tick period, restart by load, clear mid-debounce
      wait_tick(20, t1);
      wait_tick(20, t2);
      chk("t6_tick_period", 64'(t2 - t1), 64'(TD));
      nxt(); nxt(); nxt();
      keypad = NK'(1) << 6;
      wait_load(20, lc);
      wait_tick(20, t1);
      chk("t6_tick_after_load", 64'(t1 - lc), 64'(TD));
      nxt();
      keypad = '0;
      repeat (8) nxt();
      keypad = NK'(1) << 8;
      repeat (4) nxt();
      clear = 1;
      model_reset();
      #1;
      chk_zero("t6_clear");
      keypad = '0;
      nxt(); nxt();
      clear = 0;
      n0 = n_load;
      repeat (12) nxt();
      chk("t6_post_clear_no_load", 64'(n_load - n0), 64'(0));

      // randomized traffic
      for (int it = 0; it < 250; it++) begin
         r = $urandom_range(0, 7);
         if (r < 2) keypad = '0;
         else if (r < 6) begin k = $urandom_range(0, NK - 1); keypad = NK'(1) << k; end
         else keypad = NK'($urandom_range(1, (1 << NK) - 1));
         enablen = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 11) == 0);
         dur = $urandom_range(1, 9);
         nxt();
         flush = 0;
         repeat (dur - 1) nxt();
      end

      enablen = 0; flush = 0; keypad = '0;
      repeat (20) nxt();
      chk("end_events_drained", 64'(evq.size()), 64'(0));
      chk("end_ticks_drained", 64'(tickq.size()), 64'(0));
      chk("end_entry", 64'(entry), 64'(m_entry()));
      chk("end_count", 64'(count), 64'(digs.size()));
      chk("end_full", 64'(full), 64'(digs.size() == DIG));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
